// File: rtl/temp_sample_sched.sv
// temp_sample_sched
// Periodic temperature sample scheduler with running statistics.
// A free-running divider requests a sample every SAMPLE_DIV cycles. The FSM
// waits for the sensor controller to report ready, captures the reading into
// a 4-entry ring buffer and then publishes current / average / min / max
// through a mode-selected, registered output.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   tmp_rdy      sensor ready level (temp valid while high)
//   tmp_err      sensor error level, sets the sticky err flag
//   temp         signed reading, 4 fractional bits
//   mode_btn     one-cycle pulse, advances display mode modulo 4
//   clr          one-cycle pulse, clears statistics, error and in-flight sample
//   sel_temp     registered display value (0 current, 1 avg, 2 min, 3 max)
//   mode         current display mode
//   sample_valid one-cycle pulse per completed sample update
//   err          sticky error flag (sensor error or ready timeout)
module temp_sample_sched #(
   parameter int unsigned SAMPLE_DIV = 100000000,
   parameter int unsigned TO_CYCLES  = 1000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tmp_rdy,
   input  logic               tmp_err,
   input  logic signed [12:0] temp,
   input  logic               mode_btn,
   input  logic               clr,
   output logic        [12:0] sel_temp,
   output logic         [1:0] mode,
   output logic               sample_valid,
   output logic               err
);

   localparam int TW = $clog2(SAMPLE_DIV);
   localparam int OW = $clog2(TO_CYCLES + 1);

   typedef enum logic [1:0] {WAIT_TICK, WAIT_RDY, CAPTURE, UPDATE} state_t;

   state_t                   state_q;
   logic [TW-1:0]            tick_cnt_q;
   logic [OW-1:0]            to_cnt_q;
   logic [1:0]               ptr_q;
   logic signed [12:0]       ring_q [4];
   logic signed [12:0]       sample_q;
   logic                     first_q;
   logic                     sample_valid_q;
   logic                     err_q,   err_d;
   logic                     empty_q, empty_d;
   logic [1:0]               mode_q,  mode_d;
   logic signed [12:0]       cur_q,   cur_d;
   logic signed [12:0]       avg_q,   avg_d;
   logic signed [12:0]       min_q,   min_d;
   logic signed [12:0]       max_q,   max_d;
   logic [12:0]              sel_q,   sel_d;

   logic                     tick;
   logic                     timeout;
   logic signed [14:0]       sum;
   logic signed [12:0]       avg_upd, min_upd, max_upd;

   function automatic logic signed [14:0] sx(input logic signed [12:0] v);
      return {{2{v[12]}}, v};
   endfunction

   assign tick    = (tick_cnt_q == TW'(SAMPLE_DIV - 1));
   assign timeout = (state_q == WAIT_RDY) && !tmp_rdy && (to_cnt_q == OW'(TO_CYCLES - 1));

   // Ring buffer is stable during UPDATE (written on the CAPTURE edge).
   assign sum     = sx(ring_q[0]) + sx(ring_q[1]) + sx(ring_q[2]) + sx(ring_q[3]);
   assign avg_upd = 13'(sum >>> 2);
   // The first sample after empty seeds both extremes.
   assign min_upd = (first_q || sample_q < min_q) ? sample_q : min_q;
   assign max_upd = (first_q || sample_q > max_q) ? sample_q : max_q;

   // Display statistics next-state. The output mux is driven from the next
   // values so sel_temp shows the new statistics in the sample_valid cycle
   // and follows a mode change one cycle after the button pulse.
   always_comb begin
      cur_d   = cur_q;
      avg_d   = avg_q;
      min_d   = min_q;
      max_d   = max_q;
      empty_d = empty_q;
      mode_d  = mode_btn ? mode_q + 2'd1 : mode_q;
      if (clr) begin
         cur_d   = '0;
         avg_d   = '0;
         min_d   = '0;
         max_d   = '0;
         empty_d = 1'b1;
      end else begin
         if (state_q == CAPTURE) empty_d = 1'b0;
         if (state_q == UPDATE) begin
            cur_d = sample_q;
            avg_d = avg_upd;
            min_d = min_upd;
            max_d = max_upd;
         end
      end
      sel_d = '0;
      if (!empty_d) begin
         case (mode_d)
            2'd0:    sel_d = cur_d;
            2'd1:    sel_d = avg_d;
            2'd2:    sel_d = min_d;
            default: sel_d = max_d;
         endcase
      end
      // Error set wins over a simultaneous clear.
      err_d = tmp_err | (~clr & (err_q | timeout));
   end

   // Ring buffer: the first capture after empty fills every entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) ring_q[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < 4; i++) ring_q[i] <= '0;
      end else if (state_q == CAPTURE) begin
         for (int i = 0; i < 4; i++) begin
            if (empty_q || ptr_q == 2'(i)) ring_q[i] <= temp;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= WAIT_TICK;
         tick_cnt_q     <= '0;
         to_cnt_q       <= '0;
         ptr_q          <= '0;
         sample_q       <= '0;
         first_q        <= 1'b0;
         sample_valid_q <= 1'b0;
         err_q          <= 1'b0;
         empty_q        <= 1'b1;
         mode_q         <= '0;
         cur_q          <= '0;
         avg_q          <= '0;
         min_q          <= '0;
         max_q          <= '0;
         sel_q          <= '0;
      end else begin
         tick_cnt_q     <= tick ? '0 : tick_cnt_q + 1'b1;
         sample_valid_q <= (state_q == UPDATE) && !clr;
         err_q          <= err_d;
         empty_q        <= empty_d;
         mode_q         <= mode_d;
         cur_q          <= cur_d;
         avg_q          <= avg_d;
         min_q          <= min_d;
         max_q          <= max_d;
         sel_q          <= sel_d;
         if (clr) begin
            // Abandon any in-flight sample; the tick divider keeps running.
            state_q  <= WAIT_TICK;
            to_cnt_q <= '0;
            ptr_q    <= '0;
            first_q  <= 1'b0;
         end else begin
            case (state_q)
               WAIT_TICK: begin
                  if (tick) begin
                     state_q  <= WAIT_RDY;
                     to_cnt_q <= '0;
                  end
               end
               WAIT_RDY: begin
                  if (tmp_rdy)      state_q  <= CAPTURE;
                  else if (timeout) state_q  <= WAIT_TICK;
                  else              to_cnt_q <= to_cnt_q + 1'b1;
               end
               CAPTURE: begin
                  sample_q <= temp;
                  first_q  <= empty_q;
                  ptr_q    <= empty_q ? 2'd1 : ptr_q + 2'd1;
                  state_q  <= UPDATE;
               end
               default: begin
                  state_q <= WAIT_TICK;
               end
            endcase
         end
      end
   end

   assign sel_temp     = sel_q;
   assign mode         = mode_q;
   assign sample_valid = sample_valid_q;
   assign err          = err_q;

endmodule
